// File: rtl/pattern_seq_detector_if.sv
// Bus bundle between a symbol source/configuration master and the pattern_seq_detector.
// Parameters must match the detector instance that the bundle is connected to.
interface pattern_seq_detector_if #(
  parameter int DIGIT_W = 4,
  parameter int MAX_LEN = 8,
  parameter int CNT_W   = 8
);
  localparam int LEN_W = $clog2(MAX_LEN + 1);

  logic                       cfg_load;
  logic [LEN_W-1:0]           cfg_len;
  logic [DIGIT_W*MAX_LEN-1:0] cfg_pattern;
  logic                       cfg_overlap;
  logic                       in_valid;
  logic [DIGIT_W-1:0]         number;
  logic                       pattern;
  logic [CNT_W-1:0]           match_count;
  logic                       armed;
  logic                       cfg_err;

  modport master (
    output cfg_load, cfg_len, cfg_pattern, cfg_overlap, in_valid, number,
    input  pattern, match_count, armed, cfg_err
  );

  modport slave (
    input  cfg_load, cfg_len, cfg_pattern, cfg_overlap, in_valid, number,
    output pattern, match_count, armed, cfg_err
  );
endinterface

// File: rtl/pattern_seq_detector.sv
// Run-time programmable digit-sequence detector with overlap control and a saturating match counter.
//   state   | meaning
//   S_UNCFG | no valid configuration, symbols ignored
//   S_RUN   | pattern loaded, detecting
module pattern_seq_detector #(
  parameter int DIGIT_W = 4,
  parameter int MAX_LEN = 8,
  parameter int CNT_W   = 8
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  pattern_seq_detector_if.slave bus
);
  localparam int LEN_W  = $clog2(MAX_LEN + 1);
  localparam int HIST_W = DIGIT_W * MAX_LEN;

  typedef enum logic {S_UNCFG, S_RUN} state_t;

  state_t             r_state;
  logic [DIGIT_W-1:0] r_hist [MAX_LEN];
  logic [LEN_W-1:0]   r_fill;
  logic [HIST_W-1:0]  r_pat;
  logic [LEN_W-1:0]   r_len;
  logic               r_overlap;
  logic               r_pattern;
  logic [CNT_W-1:0]   r_count;
  logic               r_cfg_err;

  state_t             w_state_nxt;
  logic [DIGIT_W-1:0] w_hist_nxt [MAX_LEN];
  logic [DIGIT_W-1:0] w_shift [MAX_LEN];
  logic [LEN_W-1:0]   w_fill_nxt;
  logic [LEN_W-1:0]   w_fill_inc;
  logic [HIST_W-1:0]  w_pat_nxt;
  logic [LEN_W-1:0]   w_len_nxt;
  logic               w_overlap_nxt;
  logic               w_pattern_nxt;
  logic [CNT_W-1:0]   w_count_nxt;
  logic               w_cfg_err_nxt;
  logic               w_cfg_legal;
  logic               w_match;

  assign w_cfg_legal = (bus.cfg_len != '0) && (bus.cfg_len <= LEN_W'(MAX_LEN));

  // Match is judged on the history as it will look after this symbol is shifted in.
  always_comb begin
    w_shift[0] = bus.number;
    for (int j = 1; j < MAX_LEN; j++) begin
      w_shift[j] = r_hist[j-1];
    end

    w_fill_inc = (r_fill >= LEN_W'(MAX_LEN)) ? LEN_W'(MAX_LEN) : r_fill + LEN_W'(1);

    w_match = (r_len != '0) && (w_fill_inc >= r_len);
    for (int k = 0; k < MAX_LEN; k++) begin
      for (int j = 0; j < MAX_LEN; j++) begin
        if ((k < int'(r_len)) && (j == int'(r_len) - 1 - k) &&
            (w_shift[j] != r_pat[k*DIGIT_W +: DIGIT_W])) begin
          w_match = 1'b0;
        end
      end
    end
  end

  always_comb begin
    w_state_nxt   = r_state;
    w_hist_nxt    = r_hist;
    w_fill_nxt    = r_fill;
    w_pat_nxt     = r_pat;
    w_len_nxt     = r_len;
    w_overlap_nxt = r_overlap;
    w_pattern_nxt = 1'b0;
    w_count_nxt   = r_count;
    w_cfg_err_nxt = r_cfg_err;

    if (bus.cfg_load) begin
      // A load always restarts detection, and the symbol in this cycle is dropped.
      w_pat_nxt     = bus.cfg_pattern;
      w_len_nxt     = bus.cfg_len;
      w_overlap_nxt = bus.cfg_overlap;
      for (int j = 0; j < MAX_LEN; j++) begin
        w_hist_nxt[j] = '0;
      end
      w_fill_nxt    = '0;
      w_count_nxt   = '0;
      w_state_nxt   = w_cfg_legal ? S_RUN : S_UNCFG;
      w_cfg_err_nxt = ~w_cfg_legal;
    end else if ((r_state == S_RUN) && bus.in_valid) begin
      w_hist_nxt = w_shift;
      w_fill_nxt = w_fill_inc;
      if (w_match) begin
        w_pattern_nxt = 1'b1;
        w_count_nxt   = (r_count == '1) ? r_count : r_count + CNT_W'(1);
        if (!r_overlap) begin
          w_fill_nxt = '0;
        end
      end
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state   <= S_UNCFG;
      for (int j = 0; j < MAX_LEN; j++) begin
        r_hist[j] <= '0;
      end
      r_fill    <= '0;
      r_pat     <= '0;
      r_len     <= '0;
      r_overlap <= 1'b0;
      r_pattern <= 1'b0;
      r_count   <= '0;
      r_cfg_err <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_hist    <= w_hist_nxt;
      r_fill    <= w_fill_nxt;
      r_pat     <= w_pat_nxt;
      r_len     <= w_len_nxt;
      r_overlap <= w_overlap_nxt;
      r_pattern <= w_pattern_nxt;
      r_count   <= w_count_nxt;
      r_cfg_err <= w_cfg_err_nxt;
    end
  end

  assign bus.pattern     = r_pattern;
  assign bus.match_count = r_count;
  assign bus.armed       = (r_state == S_RUN);
  assign bus.cfg_err     = r_cfg_err;
endmodule

// File: tb/tb_pattern_seq_detector.sv
// Bench for pattern_seq_detector: directed scenarios plus random configs/streams against a queue-based model.
// Two instances share the stimulus; the second has a 2-bit counter to exercise saturation.
module tb_pattern_seq_detector;
  localparam int DW = 4;
  localparam int ML = 8;
  localparam int LW = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  pattern_seq_detector_if #(.DIGIT_W(DW), .MAX_LEN(ML), .CNT_W(8)) bus8 ();
  pattern_seq_detector_if #(.DIGIT_W(DW), .MAX_LEN(ML), .CNT_W(2)) bus2 ();

  pattern_seq_detector #(.DIGIT_W(DW), .MAX_LEN(ML), .CNT_W(8)) dut8 (
    .i_clk(clk), .i_rst(rst), .bus(bus8)
  );
  pattern_seq_detector #(.DIGIT_W(DW), .MAX_LEN(ML), .CNT_W(2)) dut2 (
    .i_clk(clk), .i_rst(rst), .bus(bus2)
  );

  int n_cmp = 0;
  int n_err = 0;
  int cyc_n = 0;

  // Reference model: digits received since the last clear, newest first.
  bit          m_armed, m_err, m_ov, m_pulse;
  int          m_len, m_cnt8, m_cnt2;
  logic [31:0] m_pat;
  logic [3:0]  m_q[$];

  logic [LW-1:0] c_len;
  logic [31:0]   c_pat;
  logic          c_ov;

  int t1 [20] = '{7,5,1,0,9,4,1,0,9,4,3,1,0,9,2,1,0,9,4,8};

  function automatic void model_reset();
    m_armed = 0; m_err = 0; m_ov = 0; m_pulse = 0;
    m_len = 0; m_cnt8 = 0; m_cnt2 = 0; m_pat = '0;
    m_q.delete();
  endfunction

  function automatic void model_edge(logic ld, logic v, logic [3:0] num);
    bit hit;
    int l;
    m_pulse = 0;
    if (ld) begin
      l = int'(c_len);
      m_armed = (l >= 1) && (l <= ML);
      m_err = !m_armed;
      m_len = l; m_pat = c_pat; m_ov = c_ov;
      m_q.delete();
      m_cnt8 = 0; m_cnt2 = 0;
    end else if (m_armed && v) begin
      m_q.push_front(num);
      if (m_q.size() > ML) void'(m_q.pop_back());
      hit = (m_q.size() >= m_len);
      for (int k = 0; k < m_len; k++)
        if (hit && (m_q[m_len-1-k] != m_pat[k*DW +: DW])) hit = 0;
      if (hit) begin
        m_pulse = 1;
        if (m_cnt8 < 255) m_cnt8++;
        if (m_cnt2 < 3) m_cnt2++;
        if (!m_ov) m_q.delete();
      end
    end
  endfunction

  task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s cycle %0d: observed %0d expected %0d", tag, cyc_n, obs, exp);
    end
  endtask

  task automatic check_all();
    chk("pattern",     32'(bus8.pattern),     32'(m_pulse));
    chk("match_count", 32'(bus8.match_count), 32'(m_cnt8));
    chk("armed",       32'(bus8.armed),       32'(m_armed));
    chk("cfg_err",     32'(bus8.cfg_err),     32'(m_err));
    chk("pattern_c2",  32'(bus2.pattern),     32'(m_pulse));
    chk("count_c2",    32'(bus2.match_count), 32'(m_cnt2));
  endtask

  task automatic drive(logic ld, logic v, logic [3:0] num);
    bus8.cfg_load = ld; bus8.cfg_len = c_len; bus8.cfg_pattern = c_pat;
    bus8.cfg_overlap = c_ov; bus8.in_valid = v; bus8.number = num;
    bus2.cfg_load = ld; bus2.cfg_len = c_len; bus2.cfg_pattern = c_pat;
    bus2.cfg_overlap = c_ov; bus2.in_valid = v; bus2.number = num;
  endtask

  task automatic cyc(logic ld, logic v, logic [3:0] num);
    drive(ld, v, num);
    @(posedge clk);
    #1;
    cyc_n++;
    model_edge(ld, v, num);
    check_all();
  endtask

  task automatic load(logic [LW-1:0] len, logic [31:0] pat, logic ov);
    c_len = len; c_pat = pat; c_ov = ov;
    cyc(1'b1, 1'b0, 4'd0);
  endtask

  task automatic send(logic [3:0] num);
    cyc(1'b0, 1'b1, num);
  endtask

  task automatic gap();
    cyc(1'b0, 1'b0, 4'd0);
  endtask

  task automatic pulse_reset();
    rst = 1'b1;
    #1;
    model_reset();
    check_all();
    @(posedge clk);
    #1;
    check_all();
    rst = 1'b0;
  endtask

  function automatic logic [3:0] rnd_digit();
    int r = int'($urandom_range(0, 5));
    return (r == 0) ? 4'hF : 4'(r % 2);
  endfunction

  initial begin
    c_len = '0; c_pat = '0; c_ov = 1'b0;
    drive(1'b0, 1'b0, 4'd0);
    model_reset();
    #1;
    check_all();
    repeat (2) @(posedge clk);
    #1;
    check_all();
    rst = 1'b0;

    // T1: overlapping 1-0-9-4
    load(4'd4, 32'h0000_4901, 1'b1);
    for (int i = 0; i < 20; i++) begin
      send(4'(t1[i]));
      chk("t1_pulse", 32'(bus8.pattern), 32'((i == 5) || (i == 9) || (i == 18)));
    end
    chk("t1_count", 32'(bus8.match_count), 32'd3);

    // T2: 1-1-1 with and without overlap
    load(4'd3, 32'h0000_0111, 1'b1);
    repeat (5) send(4'd1);
    chk("t2_ov_count", 32'(bus8.match_count), 32'd3);
    load(4'd3, 32'h0000_0111, 1'b0);
    for (int i = 0; i < 5; i++) begin
      send(4'd1);
      chk("t2_nov_pulse", 32'(bus8.pattern), 32'(i == 2));
    end
    chk("t2_nov_count", 32'(bus8.match_count), 32'd1);

    // T3: gaps between digits
    load(4'd4, 32'h0000_4901, 1'b1);
    for (int i = 0; i < 20; i++) begin
      send(4'(t1[i]));
      chk("t3_pulse", 32'(bus8.pattern), 32'((i == 5) || (i == 9) || (i == 18)));
      gap();
      chk("t3_gap", 32'(bus8.pattern), 32'd0);
      gap();
    end
    chk("t3_count", 32'(bus8.match_count), 32'd3);

    // T4: counter saturation on the 2-bit instance
    load(4'd2, 32'h0000_0055, 1'b1);
    repeat (6) send(4'd5);
    chk("t4_count_c2", 32'(bus2.match_count), 32'd3);
    chk("t4_count_c8", 32'(bus8.match_count), 32'd5);

    // T5: illegal lengths
    load(4'd0, 32'h0000_4901, 1'b1);
    chk("t5_err0", 32'(bus8.cfg_err), 32'd1);
    chk("t5_armed0", 32'(bus8.armed), 32'd0);
    load(4'd9, 32'h0000_4901, 1'b1);
    chk("t5_err9", 32'(bus8.cfg_err), 32'd1);
    for (int i = 0; i < 20; i++) send(4'(t1[i]));
    chk("t5_count", 32'(bus8.match_count), 32'd0);
    load(4'd4, 32'h0000_4901, 1'b1);
    chk("t5_err_clr", 32'(bus8.cfg_err), 32'd0);
    chk("t5_armed", 32'(bus8.armed), 32'd1);

    // T6: reset mid-match
    send(4'd1); send(4'd0); send(4'd9);
    rst = 1'b1;
    #1;
    chk("t6_rst_pattern", 32'(bus8.pattern), 32'd0);
    chk("t6_rst_count", 32'(bus8.match_count), 32'd0);
    chk("t6_rst_armed", 32'(bus8.armed), 32'd0);
    chk("t6_rst_err", 32'(bus8.cfg_err), 32'd0);
    pulse_reset();
    load(4'd4, 32'h0000_4901, 1'b1);
    send(4'd4);
    chk("t6_no_pulse", 32'(bus8.pattern), 32'd0);
    send(4'd1); send(4'd0); send(4'd9); send(4'd4);
    chk("t6_pulse", 32'(bus8.pattern), 32'd1);
    chk("t6_count", 32'(bus8.match_count), 32'd1);

    // Random configurations and streams, including load/valid collisions
    for (int n = 0; n < 40; n++) begin
      logic [LW-1:0] len;
      logic [31:0]   pat;
      if ($urandom_range(0, 9) == 0) len = ($urandom_range(0, 1) == 0) ? 4'd0 : 4'd9;
      else len = 4'($urandom_range(1, 8));
      for (int k = 0; k < ML; k++) pat[k*DW +: DW] = rnd_digit();
      load(len, pat, 1'($urandom_range(0, 1)));
      for (int s = 0; s < 30; s++) begin
        int r = int'($urandom_range(0, 19));
        if (r < 3) gap();
        else if (r == 3) cyc(1'b1, 1'b1, rnd_digit());
        else send(rnd_digit());
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
